// File: rtl/pattern_mode_if.sv
// pattern_mode_if: button, switch and auto-enable inputs plus the mode outputs
// exchanged between the pattern mode controller and the top level.
`default_nettype none

interface pattern_mode_if;
  logic       nextButton;
  logic       prevButton;
  logic       autoEnable;
  logic [9:0] switches;
  logic [4:0] currentMode;
  logic       overrideActive;
  logic       modeChanged;

  modport master (
    output nextButton,
    output prevButton,
    output autoEnable,
    output switches,
    input  currentMode,
    input  overrideActive,
    input  modeChanged
  );

  modport slave (
    input  nextButton,
    input  prevButton,
    input  autoEnable,
    input  switches,
    output currentMode,
    output overrideActive,
    output modeChanged
  );
endinterface

`default_nettype wire

// File: rtl/pattern_mode_ctrl.sv
// pattern_mode_ctrl: debounced next/prev stepping, slideshow timer and one-hot
// switch override producing the registered test-pattern mode index.
`default_nettype none

module pattern_mode_ctrl #(
  parameter int NUM_MODES       = 7,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int AUTO_PERIOD     = 250000000
) (
  input  logic           clock50MHz,
  input  logic           resetN,
  pattern_mode_if.slave  bus
);

  localparam int         DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int         AP_W     = $clog2(AUTO_PERIOD + 1);
  localparam [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam [AP_W-1:0]  AP_LAST  = AP_W'(AUTO_PERIOD - 1);
  localparam [4:0]       MODE_MAX = 5'(NUM_MODES);

  // bit 0 = next, bit 1 = prev
  logic [1:0] btn_s1, btn_s2, btn_deb, btn_deb_d, press;
  logic [9:0] sw_s1, sw_s2;

  logic       next_p, prev_p;
  logic [3:0] sw_idx;
  logic       sw_onehot, ovr;
  logic [4:0] ovr_mode;

  logic [AP_W-1:0] auto_cnt;
  logic            auto_run, tick;

  logic [4:0] stored_mode, stored_next, effective;
  logic [4:0] mode_q;
  logic       ovr_q, changed_q;

  function automatic logic [4:0] mode_inc(input logic [4:0] m);
    return (m == MODE_MAX) ? 5'd1 : m + 5'd1;
  endfunction

  function automatic logic [4:0] mode_dec(input logic [4:0] m);
    return (m == 5'd1) ? MODE_MAX : m - 5'd1;
  endfunction

  always_ff @(posedge clock50MHz) begin
    if (!resetN) begin
      btn_s1    <= '0;
      btn_s2    <= '0;
      sw_s1     <= '0;
      sw_s2     <= '0;
      btn_deb_d <= '0;
    end else begin
      btn_s1    <= {bus.prevButton, bus.nextButton};
      btn_s2    <= btn_s1;
      sw_s1     <= bus.switches;
      sw_s2     <= sw_s1;
      btn_deb_d <= btn_deb;
    end
  end

  generate
    for (genvar b = 0; b < 2; b++) begin : g_btn
      logic [DB_W-1:0] cnt;
      logic            deb;

      always_ff @(posedge clock50MHz) begin
        if (!resetN) begin
          cnt <= '0;
          deb <= 1'b0;
        end else if (btn_s2[b] != deb) begin
          if (cnt == DB_LAST) begin
            deb <= btn_s2[b];
            cnt <= '0;
          end else begin
            cnt <= cnt + DB_W'(1);
          end
        end else begin
          cnt <= '0;
        end
      end

      assign btn_deb[b] = deb;
    end
  endgenerate

  assign press  = btn_deb & ~btn_deb_d;
  assign next_p = press[0];
  assign prev_p = press[1];

  always_comb begin
    sw_idx = '0;
    for (int i = 0; i < 10; i++) begin
      if (sw_s2[i]) sw_idx = 4'(i);
    end
    sw_onehot = (sw_s2 != 10'd0) && ((sw_s2 & (sw_s2 - 10'd1)) == 10'd0);
    ovr       = sw_onehot && ({1'b0, sw_idx} < MODE_MAX);
    ovr_mode  = {1'b0, sw_idx} + 5'd1;
  end

  assign auto_run = bus.autoEnable && !ovr;
  assign tick     = auto_run && (auto_cnt == AP_LAST);

  // A press restarts the slideshow period so the next auto step is a full period away.
  always_ff @(posedge clock50MHz) begin
    if (!resetN) begin
      auto_cnt <= '0;
    end else if (!auto_run || (press != 2'b00) || tick) begin
      auto_cnt <= '0;
    end else begin
      auto_cnt <= auto_cnt + AP_W'(1);
    end
  end

  always_comb begin
    stored_next = stored_mode;
    if (!ovr) begin
      if (next_p && prev_p) begin
        stored_next = stored_mode;
      end else if (next_p) begin
        stored_next = mode_inc(stored_mode);
      end else if (prev_p) begin
        stored_next = mode_dec(stored_mode);
      end else if (tick) begin
        stored_next = mode_inc(stored_mode);
      end
    end
    effective = ovr ? ovr_mode : stored_next;
  end

  // Output register loads the next stored value directly to keep button latency at one edge past debounce.
  always_ff @(posedge clock50MHz) begin
    if (!resetN) begin
      stored_mode <= 5'd1;
      mode_q      <= 5'd1;
      ovr_q       <= 1'b0;
      changed_q   <= 1'b0;
    end else begin
      stored_mode <= stored_next;
      mode_q      <= effective;
      ovr_q       <= ovr;
      changed_q   <= (effective != mode_q);
    end
  end

  assign bus.currentMode    = mode_q;
  assign bus.overrideActive = ovr_q;
  assign bus.modeChanged    = changed_q;

endmodule

`default_nettype wire

// File: tb/tb_pattern_mode_ctrl.sv
// tb_pattern_mode_ctrl: directed checks of stepping, debounce, auto timer,
// switch override and reset behaviour with small parameter values.
`default_nettype none

module tb_pattern_mode_ctrl;
  localparam int NM = 7;
  localparam int DB = 4;
  localparam int AP = 20;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   pulse_cnt;

  pattern_mode_if bus ();

  pattern_mode_ctrl #(
    .NUM_MODES      (NM),
    .DEBOUNCE_CYCLES(DB),
    .AUTO_PERIOD    (AP)
  ) dut (
    .clock50MHz(clk),
    .resetN    (rst_n),
    .bus       (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, sampling 1 time unit after each edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (bus.modeChanged) pulse_cnt++;
    end
  endtask

  task automatic press(input logic nxt, input logic prv);
    pulse_cnt      = 0;
    bus.nextButton = nxt;
    bus.prevButton = prv;
    step(7);
    bus.nextButton = 1'b0;
    bus.prevButton = 1'b0;
    step(7);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [9:0] bad_sw [3];
    n_checks  = 0;
    n_fail    = 0;
    pulse_cnt = 0;
    rst_n          = 1'b0;
    bus.nextButton = 1'b0;
    bus.prevButton = 1'b0;
    bus.autoEnable = 1'b0;
    bus.switches   = 10'd0;
    step(3);
    rst_n = 1'b1;
    check_val("reset_mode", int'(bus.currentMode), 1);
    check_val("reset_ovr", int'(bus.overrideActive), 0);
    check_val("reset_chg", int'(bus.modeChanged), 0);

    // Clean press: change lands on edge 7 after the raw rise
    pulse_cnt      = 0;
    bus.nextButton = 1'b1;
    step(6);
    check_val("lat_edge6", int'(bus.currentMode), 1);
    step(1);
    check_val("lat_edge7", int'(bus.currentMode), 2);
    check_val("lat_chg", int'(bus.modeChanged), 1);
    step(1);
    check_val("lat_chg_drop", int'(bus.modeChanged), 0);
    step(2);
    bus.nextButton = 1'b0;
    step(10);
    check_val("release_mode", int'(bus.currentMode), 2);
    check_val("release_pulses", pulse_cnt, 1);

    // Seven next presses wrap back to 1, then prev wraps to 7
    do_reset();
    check_val("rst2_mode", int'(bus.currentMode), 1);
    for (int i = 0; i < 7; i++) begin
      press(1'b1, 1'b0);
      check_val("next_seq", int'(bus.currentMode), (i + 2 > NM) ? 1 : i + 2);
      check_val("next_pulse", pulse_cnt, 1);
    end
    press(1'b0, 1'b1);
    check_val("prev_wrap", int'(bus.currentMode), 7);

    // Bounce every 2 cycles never reaches the debounce threshold
    pulse_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      bus.nextButton = (i % 2 == 0);
      step(2);
    end
    check_val("bounce_hold", int'(bus.currentMode), 7);
    bus.nextButton = 1'b1;
    step(10);
    check_val("bounce_step", int'(bus.currentMode), 1);
    bus.nextButton = 1'b0;
    step(8);
    check_val("bounce_pulses", pulse_cnt, 1);

    press(1'b1, 1'b1);
    check_val("both_mode", int'(bus.currentMode), 1);
    check_val("both_pulses", pulse_cnt, 0);

    // Auto slideshow from mode 6
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    check_val("auto_start", int'(bus.currentMode), 6);
    bus.autoEnable = 1'b1;
    step(19);
    check_val("auto_e19", int'(bus.currentMode), 6);
    step(1);
    check_val("auto_e20", int'(bus.currentMode), 7);
    step(19);
    check_val("auto_e39", int'(bus.currentMode), 7);
    step(1);
    check_val("auto_e40", int'(bus.currentMode), 1);
    step(8);
    bus.nextButton = 1'b1;
    step(6);
    check_val("auto_e54", int'(bus.currentMode), 1);
    step(1);
    check_val("auto_press_e55", int'(bus.currentMode), 2);
    step(2);
    bus.nextButton = 1'b0;
    step(3);
    check_val("auto_e60_restart", int'(bus.currentMode), 2);
    step(14);
    check_val("auto_e74", int'(bus.currentMode), 2);
    step(1);
    check_val("auto_e75", int'(bus.currentMode), 3);
    step(13);
    bus.nextButton = 1'b1;
    step(7);
    check_val("auto_coincide", int'(bus.currentMode), 4);
    step(1);
    check_val("auto_coincide_after", int'(bus.currentMode), 4);
    bus.nextButton = 1'b0;
    bus.autoEnable = 1'b0;
    step(8);

    // Switch override from stored mode 2
    do_reset();
    press(1'b1, 1'b0);
    check_val("ovr_base", int'(bus.currentMode), 2);
    bus.switches = 10'b0000100000;
    step(2);
    check_val("ovr_e2_mode", int'(bus.currentMode), 2);
    check_val("ovr_e2_flag", int'(bus.overrideActive), 0);
    step(1);
    check_val("ovr_e3_mode", int'(bus.currentMode), 6);
    check_val("ovr_e3_flag", int'(bus.overrideActive), 1);
    check_val("ovr_e3_chg", int'(bus.modeChanged), 1);
    press(1'b1, 1'b0);
    check_val("ovr_ignore_press", int'(bus.currentMode), 6);
    check_val("ovr_ignore_pulses", pulse_cnt, 0);
    bus.switches = 10'd0;
    step(3);
    check_val("ovr_release_mode", int'(bus.currentMode), 2);
    check_val("ovr_release_flag", int'(bus.overrideActive), 0);

    bad_sw[0] = 10'b1000000000;
    bad_sw[1] = 10'b0000000011;
    bad_sw[2] = 10'b0010000000;
    for (int i = 0; i < 3; i++) begin
      bus.switches = bad_sw[i];
      step(3);
      check_val("no_ovr_flag", int'(bus.overrideActive), 0);
      check_val("no_ovr_mode", int'(bus.currentMode), 2);
    end
    bus.switches = 10'b0001000000;
    step(3);
    check_val("ovr_top_mode", int'(bus.currentMode), 7);
    check_val("ovr_top_flag", int'(bus.overrideActive), 1);
    bus.switches = 10'd0;
    step(3);
    pulse_cnt    = 0;
    bus.switches = 10'b0000000010;
    step(3);
    check_val("ovr_same_flag", int'(bus.overrideActive), 1);
    check_val("ovr_same_mode", int'(bus.currentMode), 2);
    check_val("ovr_same_pulses", pulse_cnt, 0);
    bus.switches = 10'd0;
    step(3);

    // Reset mid-debounce, button released: press discarded
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    check_val("mid_base", int'(bus.currentMode), 5);
    bus.nextButton = 1'b1;
    step(4);
    rst_n          = 1'b0;
    bus.nextButton = 1'b0;
    step(1);
    check_val("mid_rst_mode", int'(bus.currentMode), 1);
    check_val("mid_rst_chg", int'(bus.modeChanged), 0);
    rst_n = 1'b1;
    step(10);
    check_val("mid_discard", int'(bus.currentMode), 1);

    // Reset mid-debounce, button held: one step after a full debounce
    pulse_cnt      = 0;
    bus.nextButton = 1'b1;
    step(4);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    check_val("held_rst_mode", int'(bus.currentMode), 1);
    step(6);
    check_val("held_e6", int'(bus.currentMode), 1);
    step(1);
    check_val("held_e7", int'(bus.currentMode), 2);
    bus.nextButton = 1'b0;
    step(8);
    check_val("held_pulses", pulse_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
